// File: rtl/axi_sram_slv.sv
// axi_sram_slv: AXI4 slave over a word-addressed register array, one outstanding burst per direction.
// Optional feature macro AXI_SLV_ERR_EN: flag out-of-range beats with SLVERR instead of aliasing.

typedef struct packed {
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        rready;
} s_axi_mosi_t;

typedef struct packed {
  logic        awready;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
} s_axi_miso_t;

module axi_sram_slv #(
  parameter int          MEM_KB    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int         WORDS       = MEM_KB * 256;
  localparam int         IW          = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [31:0] step;
    step = (size > 3'd2) ? 32'd4 : (32'd1 << size);
    return (burst == 2'b00) ? addr : addr + step;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] w;
    w = ((addr - BASE_ADDR) >> 2) % 32'(WORDS);
    return w[IW-1:0];
  endfunction

`ifdef AXI_SLV_ERR_EN
  function automatic logic out_of_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr < BASE_ADDR) || ((off >> 2) >= 32'(WORDS));
  endfunction
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      else         res[8*i +: 8] = old[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0] mem [WORDS];

  w_state_t    w_state_r;
  logic [3:0]  w_id_r;
  logic [31:0] w_addr_r;
  logic [7:0]  w_len_r, w_cnt_r;
  logic [2:0]  w_size_r;
  logic [1:0]  w_burst_r, bresp_r;
  logic        w_err_r, awready_r, wready_r, bvalid_r;

  r_state_t    r_state_r;
  logic [3:0]  r_id_r;
  logic [31:0] r_addr_r, rdata_r;
  logic [7:0]  r_len_r, r_cnt_r;
  logic [2:0]  r_size_r;
  logic [1:0]  r_burst_r, rresp_r;
  logic        arready_r, rvalid_r, rlast_r;

  logic          w_beat_s, wr_flag_s, wr_en_s;
  logic [IW-1:0] wr_idx_s, rd_idx_s;
  logic [31:0]   rd_addr_s, rd_word_s;
  logic          rd_flag_s, r_adv_s;
  logic          unused_s;

  assign unused_s = axi_mosi_i.wlast;

  // Write-beat qualification; writes are dropped while reset is asserted
  always_comb begin
    w_beat_s = wready_r & axi_mosi_i.wvalid;
`ifdef AXI_SLV_ERR_EN
    wr_flag_s = out_of_range(w_addr_r);
`else
    wr_flag_s = 1'b0;
`endif
    wr_en_s  = w_beat_s & ~wr_flag_s & ~rst;
    wr_idx_s = word_idx(w_addr_r);
  end

  // Address of the beat presented next cycle; its word includes any same-edge write
  always_comb begin
    r_adv_s = rvalid_r & axi_mosi_i.rready & ~rlast_r;
    if (r_state_r == R_IDLE) rd_addr_s = axi_mosi_i.araddr;
    else if (r_adv_s)        rd_addr_s = next_addr(r_addr_r, r_size_r, r_burst_r);
    else                     rd_addr_s = r_addr_r;
    rd_idx_s = word_idx(rd_addr_s);
    if (wr_en_s && (wr_idx_s == rd_idx_s))
      rd_word_s = merge_bytes(mem[rd_idx_s], axi_mosi_i.wdata, axi_mosi_i.wstrb);
    else
      rd_word_s = mem[rd_idx_s];
`ifdef AXI_SLV_ERR_EN
    rd_flag_s = out_of_range(rd_addr_s);
`else
    rd_flag_s = 1'b0;
`endif
  end

  // Storage array, byte-lane writes, never reset
  always_ff @(posedge clk) begin
    if (wr_en_s) mem[wr_idx_s] <= merge_bytes(mem[wr_idx_s], axi_mosi_i.wdata, axi_mosi_i.wstrb);
  end

  // Write channel FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      w_err_r   <= 1'b0;
      w_id_r    <= 4'd0;
      w_addr_r  <= 32'd0;
      w_len_r   <= 8'd0;
      w_cnt_r   <= 8'd0;
      w_size_r  <= 3'd0;
      w_burst_r <= 2'd0;
    end else begin
      case (w_state_r)
        W_IDLE: if (axi_mosi_i.awvalid) begin
          w_id_r    <= axi_mosi_i.awid;
          w_addr_r  <= axi_mosi_i.awaddr;
          w_len_r   <= axi_mosi_i.awlen;
          w_size_r  <= axi_mosi_i.awsize;
          w_burst_r <= axi_mosi_i.awburst;
          w_cnt_r   <= 8'd0;
          awready_r <= 1'b0;
          wready_r  <= 1'b1;
          w_state_r <= W_DATA;
        end
        W_DATA: if (w_beat_s) begin
          w_addr_r <= next_addr(w_addr_r, w_size_r, w_burst_r);
          w_cnt_r  <= w_cnt_r + 8'd1;
          w_err_r  <= w_err_r | wr_flag_s;
          if (w_cnt_r == w_len_r) begin
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= (w_err_r | wr_flag_s) ? RESP_SLVERR : RESP_OKAY;
            w_state_r <= W_RESP;
          end
        end
        W_RESP: if (axi_mosi_i.bready) begin
          bvalid_r  <= 1'b0;
          bresp_r   <= RESP_OKAY;
          w_err_r   <= 1'b0;
          awready_r <= 1'b1;
          w_state_r <= W_IDLE;
        end
        default: begin
          bvalid_r  <= 1'b0;
          wready_r  <= 1'b0;
          awready_r <= 1'b1;
          w_err_r   <= 1'b0;
          w_state_r <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM; rdata is reloaded every cycle in R_DATA so it tracks writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= RESP_OKAY;
      r_id_r    <= 4'd0;
      r_addr_r  <= 32'd0;
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'd0;
    end else begin
      case (r_state_r)
        R_IDLE: if (axi_mosi_i.arvalid) begin
          r_id_r    <= axi_mosi_i.arid;
          r_addr_r  <= rd_addr_s;
          r_len_r   <= axi_mosi_i.arlen;
          r_size_r  <= axi_mosi_i.arsize;
          r_burst_r <= axi_mosi_i.arburst;
          r_cnt_r   <= 8'd0;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b1;
          rlast_r   <= (axi_mosi_i.arlen == 8'd0);
          rdata_r   <= rd_flag_s ? 32'hDEAD_BEEF : rd_word_s;
          rresp_r   <= rd_flag_s ? RESP_SLVERR : RESP_OKAY;
          r_state_r <= R_DATA;
        end
        R_DATA: if (axi_mosi_i.rready && rlast_r) begin
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
          rresp_r   <= RESP_OKAY;
          arready_r <= 1'b1;
          r_state_r <= R_IDLE;
        end else begin
          if (r_adv_s) begin
            r_cnt_r <= r_cnt_r + 8'd1;
            rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
          end
          r_addr_r <= rd_addr_s;
          rdata_r  <= rd_flag_s ? 32'hDEAD_BEEF : rd_word_s;
          rresp_r  <= rd_flag_s ? RESP_SLVERR : RESP_OKAY;
        end
        default: begin
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
          arready_r <= 1'b1;
          r_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Output bundle; address readies are masked by reset so they rise as soon as it drops
  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = awready_r & ~rst;
    axi_miso_o.wready  = wready_r;
    axi_miso_o.bid     = w_id_r;
    axi_miso_o.bresp   = bresp_r;
    axi_miso_o.bvalid  = bvalid_r;
    axi_miso_o.arready = arready_r & ~rst;
    axi_miso_o.rid     = r_id_r;
    axi_miso_o.rdata   = rdata_r;
    axi_miso_o.rresp   = rresp_r;
    axi_miso_o.rlast   = rlast_r;
    axi_miso_o.rvalid  = rvalid_r;
  end

endmodule

// File: tb/tb_axi_sram_slv.sv
// tb_axi_sram_slv: directed vector table plus hand sequences for bursts, concurrency,
// out-of-range handling (both AXI_SLV_ERR_EN builds) and reset mid-burst.

module tb_axi_sram_slv;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          MEM_KB = 8;
  localparam int          NV     = 16;

  typedef struct {
    logic        is_wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vecs [NV];
  logic [31:0] ex [8];

  axi_sram_slv #(.MEM_KB(MEM_KB), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi_mosi_i(mosi),
    .axi_miso_o(miso)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_single(input string name, input logic [3:0] id, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb, input logic [1:0] exp_resp);
    chk({name, ".awready_idle"}, 32'(miso.awready), 32'd1);
    mosi.awvalid = 1'b1; mosi.awid = id; mosi.awaddr = addr;
    mosi.awlen = 8'd0; mosi.awsize = 3'd2; mosi.awburst = 2'b01;
    tick();
    mosi.awvalid = 1'b0;
    chk({name, ".awready_busy"}, 32'(miso.awready), 32'd0);
    chk({name, ".wready"}, 32'(miso.wready), 32'd1);
    chk({name, ".bvalid_early"}, 32'(miso.bvalid), 32'd0);
    mosi.wvalid = 1'b1; mosi.wdata = data; mosi.wstrb = strb; mosi.wlast = 1'b1;
    tick();
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0;
    chk({name, ".bvalid"}, 32'(miso.bvalid), 32'd1);
    chk({name, ".bresp"}, 32'(miso.bresp), 32'(exp_resp));
    chk({name, ".bid"}, 32'(miso.bid), 32'(id));
    mosi.bready = 1'b1;
    tick();
    mosi.bready = 1'b0;
    chk({name, ".bvalid_done"}, 32'(miso.bvalid), 32'd0);
    chk({name, ".awready_back"}, 32'(miso.awready), 32'd1);
  endtask

  task automatic read_burst(input string name, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] exp_data [8], input logic [1:0] exp_resp, input bit stall);
    int beat;
    beat = 0;
    chk({name, ".arready_idle"}, 32'(miso.arready), 32'd1);
    mosi.arvalid = 1'b1; mosi.arid = id; mosi.araddr = addr;
    mosi.arlen = len; mosi.arsize = size; mosi.arburst = burst;
    tick();
    mosi.arvalid = 1'b0;
    for (int cyc = 0; cyc < 40 && beat <= int'(len); cyc++) begin
      chk({name, ".rvalid"}, 32'(miso.rvalid), 32'd1);
      chk({name, ".rdata"}, miso.rdata, exp_data[beat]);
      chk({name, ".rresp"}, 32'(miso.rresp), 32'(exp_resp));
      chk({name, ".rlast"}, 32'(miso.rlast), 32'(beat == int'(len)));
      chk({name, ".rid"}, 32'(miso.rid), 32'(id));
      chk({name, ".arready_busy"}, 32'(miso.arready), 32'd0);
      mosi.rready = stall ? (cyc % 2 == 0) : 1'b1;
      tick();
      if (mosi.rready) beat++;
      mosi.rready = 1'b0;
    end
    chk({name, ".beats"}, 32'(beat), 32'(int'(len) + 1));
    chk({name, ".rvalid_done"}, 32'(miso.rvalid), 32'd0);
    chk({name, ".arready_back"}, 32'(miso.arready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h1, BASE + 32'h10,   32'hCAFE_BABE, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 4'h2, BASE + 32'h10,   32'h0,         4'h0, 32'hCAFE_BABE};
    vecs[2]  = '{1'b1, 4'h3, BASE + 32'h20,   32'h1122_3344, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 4'h4, BASE + 32'h20,   32'hAABB_CCDD, 4'h5, 32'h0};
    vecs[4]  = '{1'b0, 4'h5, BASE + 32'h20,   32'h0,         4'h0, 32'h11BB_33DD};
    vecs[5]  = '{1'b1, 4'h6, BASE + 32'h24,   32'h1234_5678, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 4'h7, BASE + 32'h24,   32'hFFFF_FFFF, 4'h8, 32'h0};
    vecs[7]  = '{1'b0, 4'h8, BASE + 32'h24,   32'h0,         4'h0, 32'hFF34_5678};
    vecs[8]  = '{1'b1, 4'h9, BASE + 32'h1FFC, 32'hA5A5_A5A5, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 4'hA, BASE + 32'h1FFC, 32'h0,         4'h0, 32'hA5A5_A5A5};
    vecs[10] = '{1'b1, 4'hB, BASE + 32'h00,   32'hA000_0000, 4'hF, 32'h0};
    vecs[11] = '{1'b1, 4'hC, BASE + 32'h04,   32'hA000_0001, 4'hF, 32'h0};
    vecs[12] = '{1'b1, 4'hD, BASE + 32'h08,   32'hA000_0002, 4'hF, 32'h0};
    vecs[13] = '{1'b1, 4'hE, BASE + 32'h0C,   32'hA000_0003, 4'hF, 32'h0};
    vecs[14] = '{1'b1, 4'hF, BASE + 32'h14,   32'h5555_0000, 4'hF, 32'h0};
    vecs[15] = '{1'b0, 4'h0, BASE + 32'h10,   32'h0,         4'h0, 32'hCAFE_BABE};

    mosi = '0;
    rst  = 1'b1;
    repeat (3) tick();
    chk("rst.awready", 32'(miso.awready), 32'd0);
    chk("rst.wready", 32'(miso.wready), 32'd0);
    chk("rst.bvalid", 32'(miso.bvalid), 32'd0);
    chk("rst.arready", 32'(miso.arready), 32'd0);
    chk("rst.rvalid", 32'(miso.rvalid), 32'd0);
    chk("rst.rdata", miso.rdata, 32'd0);
    chk("rst.rlast", 32'(miso.rlast), 32'd0);
    chk("rst.bresp", 32'(miso.bresp), 32'd0);
    chk("rst.rresp", 32'(miso.rresp), 32'd0);
    chk("rst.bid", 32'(miso.bid), 32'd0);
    chk("rst.rid", 32'(miso.rid), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst.awready", 32'(miso.awready), 32'd1);
    chk("post_rst.arready", 32'(miso.arready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        write_single($sformatf("vec%0d_wr", i), vecs[i].id, vecs[i].addr, vecs[i].data, vecs[i].strb, 2'b00);
      end else begin
        ex = '{vecs[i].exp_data, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        read_burst($sformatf("vec%0d_rd", i), vecs[i].id, vecs[i].addr, 8'd0, 3'd2, 2'b01, ex, 2'b00, 1'b0);
      end
    end

    // INCR with rready toggling, then FIXED, then byte-sized INCR crossing a word
    ex = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'h0, 32'h0, 32'h0, 32'h0};
    read_burst("incr_bp", 4'h3, BASE, 8'd3, 3'd2, 2'b01, ex, 2'b00, 1'b1);
    ex = '{32'hA000_0001, 32'hA000_0001, 32'hA000_0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    read_burst("fixed", 4'h4, BASE + 32'h4, 8'd2, 3'd2, 2'b00, ex, 2'b00, 1'b0);
    ex = '{32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'h5555_0000, 32'h0, 32'h0, 32'h0};
    read_burst("incr_size0", 4'h5, BASE + 32'h10, 8'd4, 3'd0, 2'b01, ex, 2'b00, 1'b0);

    // W beat to word 5 lands on the edge that R hands over word 5
    mosi.awvalid = 1'b1; mosi.awid = 4'h5; mosi.awaddr = BASE + 32'h14;
    mosi.awlen = 8'd0; mosi.awsize = 3'd2; mosi.awburst = 2'b01;
    mosi.arvalid = 1'b1; mosi.arid = 4'h6; mosi.araddr = BASE + 32'h14;
    mosi.arlen = 8'd0; mosi.arsize = 3'd2; mosi.arburst = 2'b01;
    tick();
    mosi.awvalid = 1'b0; mosi.arvalid = 1'b0;
    chk("rw_same.rvalid", 32'(miso.rvalid), 32'd1);
    chk("rw_same.wready", 32'(miso.wready), 32'd1);
    chk("rw_same.rdata_old", miso.rdata, 32'h5555_0000);
    mosi.wvalid = 1'b1; mosi.wdata = 32'h7777_8888; mosi.wstrb = 4'hF; mosi.rready = 1'b1;
    tick();
    mosi.wvalid = 1'b0; mosi.rready = 1'b0;
    chk("rw_same.bvalid", 32'(miso.bvalid), 32'd1);
    chk("rw_same.rvalid_done", 32'(miso.rvalid), 32'd0);
    mosi.bready = 1'b1;
    tick();
    mosi.bready = 1'b0;
    ex = '{32'h7777_8888, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    read_burst("rw_new", 4'h7, BASE + 32'h14, 8'd0, 3'd2, 2'b01, ex, 2'b00, 1'b0);

`ifdef AXI_SLV_ERR_EN
    write_single("oor_wr", 4'h7, BASE + 32'h2000, 32'h1234_5678, 4'hF, 2'b10);
    ex = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    read_burst("oor_rd", 4'h8, BASE + 32'h2000, 8'd0, 3'd2, 2'b01, ex, 2'b10, 1'b0);
    read_burst("below_base_rd", 4'h9, BASE - 32'h4, 8'd0, 3'd2, 2'b01, ex, 2'b10, 1'b0);
    write_single("oor_clear", 4'h1, BASE + 32'h30, 32'h0000_0030, 4'hF, 2'b00);
    ex = '{32'hA000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    read_burst("oor_word0", 4'hA, BASE, 8'd0, 3'd2, 2'b01, ex, 2'b00, 1'b0);
`else
    write_single("oor_wr", 4'h7, BASE + 32'h2000, 32'h1234_5678, 4'hF, 2'b00);
    ex = '{32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    read_burst("oor_rd", 4'h8, BASE + 32'h2000, 8'd0, 3'd2, 2'b01, ex, 2'b00, 1'b0);
    read_burst("oor_alias0", 4'h9, BASE, 8'd0, 3'd2, 2'b01, ex, 2'b00, 1'b0);
`endif

    // Reset during beat 2 of an 8-beat write
    mosi.awvalid = 1'b1; mosi.awid = 4'h9; mosi.awaddr = BASE + 32'h40;
    mosi.awlen = 8'd7; mosi.awsize = 3'd2; mosi.awburst = 2'b01;
    tick();
    mosi.awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mosi.wvalid = 1'b1; mosi.wdata = 32'hB000_0000 + 32'(b); mosi.wstrb = 4'hF;
      tick();
    end
    mosi.wdata = 32'hB000_0002;
    rst = 1'b1;
    tick();
    mosi.wvalid = 1'b0;
    chk("rst_mid.bvalid", 32'(miso.bvalid), 32'd0);
    chk("rst_mid.awready", 32'(miso.awready), 32'd0);
    chk("rst_mid.wready", 32'(miso.wready), 32'd0);
    chk("rst_mid.arready", 32'(miso.arready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid.awready_after", 32'(miso.awready), 32'd1);
    chk("rst_mid.bvalid_after", 32'(miso.bvalid), 32'd0);
    chk("rst_mid.wready_after", 32'(miso.wready), 32'd0);
    tick();
    chk("rst_mid.bvalid_later", 32'(miso.bvalid), 32'd0);
    ex = '{32'hB000_0000, 32'hB000_0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    read_burst("rst_mid.partial", 4'h2, BASE + 32'h40, 8'd1, 3'd2, 2'b01, ex, 2'b00, 1'b0);
    write_single("rst_mid.new_wr", 4'hC, BASE + 32'h40, 32'hC0DE_C0DE, 4'hF, 2'b00);
    ex = '{32'hC0DE_C0DE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    read_burst("rst_mid.new_rd", 4'hD, BASE + 32'h40, 8'd0, 3'd2, 2'b01, ex, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
